// File: rtl/scramble_tx_ctrl.sv
// PRBS7-scrambled byte serialiser: byte handshake in LOAD, 8 LSB-first bits 1 cycle later, plus an even-parity bit when PARITY_BIT_EN is defined.
// Source backpressure is byte_valid low in LOAD (LFSR holds); abort returns to IDLE on the next edge with no frame_done.
module scramble_tx_ctrl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] frame_len,
   input  logic [6:0] seed,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PARITY, DONE} state_t;

   state_t     state_q, state_d;
   logic [6:0] lfsr_q, lfsr_d;
   logic [3:0] byte_cnt_q, byte_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] byte_q, byte_d;
   logic       par_q, par_d;
   logic       bit_out_q, bit_out_d;
   logic       bit_valid_q, bit_valid_d;
   logic       frame_done_q, frame_done_d;

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      byte_cnt_d   = byte_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      byte_d       = byte_q;
      par_d        = par_q;
      bit_out_d    = 1'b0;
      bit_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (frame_len != 4'd0)) begin
               state_d    = LOAD;
               byte_cnt_d = frame_len;
               lfsr_d     = (seed == 7'd0) ? 7'h7F : seed;
            end
         end
         LOAD: begin
            if (byte_valid) begin
               byte_d    = byte_data;
               bit_cnt_d = 3'd0;
               par_d     = 1'b0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            bit_out_d   = byte_q[bit_cnt_q] ^ lfsr_q[6];
            bit_valid_d = 1'b1;
            par_d       = par_q ^ bit_out_d;
            lfsr_d      = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               if (byte_cnt_q != 4'd0)
                  byte_cnt_d = byte_cnt_q - 4'd1;
`ifdef PARITY_BIT_EN
               state_d = PARITY;
`else
               state_d = (byte_cnt_q > 4'd1) ? LOAD : DONE;
`endif
            end
         end
`ifdef PARITY_BIT_EN
         // byte counter was already decremented on SHIFT exit
         PARITY: begin
            bit_out_d   = par_q;
            bit_valid_d = 1'b1;
            state_d     = (byte_cnt_q != 4'd0) ? LOAD : DONE;
         end
`endif
         DONE: begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) begin
         state_d      = IDLE;
         byte_cnt_d   = 4'd0;
         bit_out_d    = 1'b0;
         bit_valid_d  = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         lfsr_q       <= 7'h7F;
         byte_cnt_q   <= 4'd0;
         bit_cnt_q    <= 3'd0;
         byte_q       <= 8'd0;
         par_q        <= 1'b0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         byte_cnt_q   <= byte_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_q       <= byte_d;
         par_q        <= par_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign byte_ready = (state_q == LOAD) && !abort;
   assign busy       = (state_q != IDLE);
   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scramble_tx_ctrl.sv
// Bench for scramble_tx_ctrl: expected scrambled bits are queued at each byte handshake and popped as bit_valid bits appear.
module tb_scramble_tx_ctrl;

`ifdef PARITY_BIT_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] frame_len = 4'd0;
   logic [6:0] seed = 7'd0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'd0;
   logic       byte_ready, bit_out, bit_valid, busy, frame_done;

   scramble_tx_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .frame_len  (frame_len),
      .seed       (seed),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   logic        exp_q[$];
   int          obs_cnt = 0;
   logic [15:0] obs_vec = '0;
   int          done_cnt = 0;
   int          done_base = 0;
   logic [6:0]  m_lfsr = 7'h7F;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic e;
      if (reset_n) begin
         if (bit_valid) begin
            if (obs_cnt < 16) obs_vec[obs_cnt] = bit_out;
            obs_cnt++;
            if (exp_q.size() == 0) begin
               chk("extra_bit", 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk("bit", 32'(bit_out), 32'(e));
            end
         end
         if (frame_done) done_cnt++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic frame_begin(input logic [3:0] len, input logic [6:0] sd);
      obs_cnt   = 0;
      obs_vec   = '0;
      done_base = done_cnt;
      start     = 1'b1;
      frame_len = len;
      seed      = sd;
      step();
      start     = 1'b0;
      m_lfsr    = (sd == 7'd0) ? 7'h7F : sd;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int  n = 0;
      logic p = 1'b0;
      logic e;
      while (!byte_ready && n < 100) begin
         step();
         n++;
      end
      if (!byte_ready) begin
         chk("rdy_timeout", 32'(0), 32'(1));
         return;
      end
      for (int g = 0; g < gap; g++) begin
         step();
         chk("gap_bit_valid", 32'(bit_valid), 32'(0));
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 8; i++) begin
         e = b[i] ^ m_lfsr[6];
         exp_q.push_back(e);
         p = p ^ e;
         m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      end
      if (PAR != 0) exp_q.push_back(p);
      step();
      byte_valid = 1'b0;
   endtask

   task automatic wait_end(input int exp_bits);
      int n = 0;
      while (done_cnt == done_base && n < 300) begin
         step();
         n++;
      end
      chk("done_timeout", 32'(done_cnt != done_base), 32'(1));
      chk("busy_end", 32'(busy), 32'(0));
      step();
      step();
      chk("done_once", 32'(done_cnt - done_base), 32'(1));
      chk("bit_count", 32'(obs_cnt), 32'(exp_bits));
      chk("queue_empty", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic wait_bits(input int target);
      int n = 0;
      while (obs_cnt < target && n < 300) begin
         step();
         n++;
      end
      chk("bits_timeout", 32'(obs_cnt), 32'(target));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_bit_valid", 32'(bit_valid), 32'(0));
      chk("rst_bit_out", 32'(bit_out), 32'(0));
      chk("rst_frame_done", 32'(frame_done), 32'(0));
      chk("rst_byte_ready", 32'(byte_ready), 32'(0));
      reset_n = 1'b1;
      step();

      // single zero byte, seed 7F: fixed known sequence
      frame_begin(4'd1, 7'h7F);
      chk("load_busy", 32'(busy), 32'(1));
      chk("load_byte_ready", 32'(byte_ready), 32'(1));
      send_byte(8'h00, 0);
      wait_end(8 + PAR);
      chk("seq_seed7f", 32'(obs_vec[7:0]), 32'(8'h7F));
      if (PAR != 0) chk("parity_bit", 32'(obs_vec[8]), 32'(1));

      // seed 0 behaves as 7F
      frame_begin(4'd1, 7'h00);
      send_byte(8'h00, 0);
      wait_end(8 + PAR);
      chk("seq_seed0", 32'(obs_vec[7:0]), 32'(8'h7F));

      // three bytes with source gaps
      frame_begin(4'd3, 7'h4B);
      send_byte(8'hA5, 0);
      send_byte(8'h3C, 5);
      send_byte(8'hF0, 2);
      wait_end(3 * (8 + PAR));

      // abort on 4th bit of byte 2, then immediate restart
      frame_begin(4'd3, 7'h25);
      send_byte(8'h11, 0);
      send_byte(8'h96, 0);
      wait_bits(8 + PAR + 4);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_bit_valid", 32'(bit_valid), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_no_done", 32'(done_cnt - done_base), 32'(0));
      exp_q.delete();
      frame_begin(4'd1, 7'h7F);
      chk("restart_busy", 32'(busy), 32'(1));
      send_byte(8'h00, 0);
      wait_end(8 + PAR);
      chk("restart_seq", 32'(obs_vec[7:0]), 32'(8'h7F));

      // zero-length start and start while busy are ignored
      start = 1'b1;
      frame_len = 4'd0;
      seed = 7'h12;
      step();
      start = 1'b0;
      chk("len0_ignored", 32'(busy), 32'(0));
      frame_begin(4'd2, 7'h33);
      start = 1'b1;
      frame_len = 4'd9;
      seed = 7'h01;
      step();
      start = 1'b0;
      chk("busy_start_busy", 32'(busy), 32'(1));
      chk("len_latched", 32'(dut.byte_cnt_q), 32'(2));
      send_byte(8'h5E, 0);
      start = 1'b1;
      send_byte(8'hE7, 1);
      start = 1'b0;
      wait_end(2 * (8 + PAR));

      // asynchronous reset in the middle of a byte
      frame_begin(4'd2, 7'h5A);
      send_byte(8'hC3, 0);
      wait_bits(3);
      reset_n = 1'b0;
      #1;
      chk("arst_bit_valid", 32'(bit_valid), 32'(0));
      chk("arst_bit_out", 32'(bit_out), 32'(0));
      chk("arst_busy", 32'(busy), 32'(0));
      chk("arst_byte_ready", 32'(byte_ready), 32'(0));
      chk("arst_frame_done", 32'(frame_done), 32'(0));
      chk("arst_lfsr", 32'(dut.lfsr_q), 32'(7'h7F));
      step();
      step();
      exp_q.delete();
      reset_n = 1'b1;
      repeat (20) step();
      chk("post_rst_busy", 32'(busy), 32'(0));
      chk("post_rst_no_bits", 32'(obs_cnt), 32'(3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
